// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding and byte width.
// Optional requester lock is enabled with `define UART_TX_ARB_LOCK_EN.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. Shared by any peripheral with a rotating owner.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int          j;
  logic [ID_W-1:0] j_id;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    j    = 0;
    j_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_id = ID_W'(j);
      if (en && !any && req[j_id]) begin
        gnt[j_id] = 1'b1;
        idx       = j_id;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX among NUM_REQ byte sources.
// Define UART_TX_ARB_LOCK_EN to add i_ReqLock for unbroken multi-byte messages.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  localparam int REQ_ID_W = $clog2(NUM_REQ)
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  input  logic                      i_Enable,
  input  logic [NUM_REQ-1:0]        i_ReqValid,
  input  logic [BYTE_W*NUM_REQ-1:0] i_ReqData,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        i_ReqLock,
`endif
  output logic [NUM_REQ-1:0]        o_ReqReady,
  output logic [REQ_ID_W-1:0]       o_GrantId,
  output logic                      o_Busy,
  output logic                      o_TxEn,
  output logic [BYTE_W-1:0]         o_TxData,
  input  logic                      i_TxIdle
);

  tx_state_e             state, state_nxt;
  logic [REQ_ID_W-1:0]   ptr, ptr_nxt, arb_ptr, win_id;
  logic [NUM_REQ-1:0]    req_vec, win_gnt;
  logic                  win_any, arb_en, grant, ptr_adv, frame_end;
  logic [BYTE_W-1:0]     sel_byte;

  assign arb_en    = (state == IDLE) && i_Enable && i_TxIdle;
  assign grant     = win_any;
  assign frame_end = (state == WAIT_DONE) && i_TxIdle;
  assign sel_byte  = BYTE_W'(i_ReqData >> (BYTE_W * int'(win_id)));
  assign ptr_nxt   = (win_id == REQ_ID_W'(NUM_REQ - 1)) ? '0
                   : win_id + 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_act, lock_hold;

  // Owner keeps the transmitter while it holds lock and still has data.
  assign lock_hold = lock_act && i_ReqLock[o_GrantId]
                   && i_ReqValid[o_GrantId];
  assign req_vec   = lock_hold ? (NUM_REQ'(1) << o_GrantId)
                   : i_ReqValid;
  assign arb_ptr   = lock_hold ? o_GrantId : ptr;
  assign ptr_adv   = !lock_hold;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      lock_act <= 1'b0;
    else if (frame_end)
      lock_act <= i_ReqLock[o_GrantId];
    else if (state == IDLE && !lock_hold)
      lock_act <= 1'b0;
  end
`else
  assign req_vec = i_ReqValid;
  assign arb_ptr = ptr;
  assign ptr_adv = 1'b1;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_vec),
    .ptr (arb_ptr),
    .en  (arb_en),
    .gnt (win_gnt),
    .idx (win_id),
    .any (win_any)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (grant && ptr_adv) ptr <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (grant) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!i_TxIdle) state_nxt = WAIT_DONE;
      WAIT_DONE: if (i_TxIdle) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // TX samples o_TxData bit by bit, so it only moves on a new grant.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_ReqReady <= '0;
      o_TxEn     <= 1'b0;
      o_TxData   <= '0;
      o_GrantId  <= '0;
      o_Busy     <= 1'b0;
    end else begin
      o_ReqReady <= grant ? win_gnt : '0;
      o_TxEn     <= (state == START);
      if (grant) begin
        o_TxData  <= sel_byte;
        o_GrantId <= win_id;
        o_Busy    <= 1'b1;
      end else if (frame_end) begin
        o_Busy    <= 1'b0;
      end
    end
  end

endmodule
